triangle_timer_ctrl: RTL and testbench

- Upstream control stage for triangle_generator in the NES APU triangle channel.
- Holds the channel's register-mapped state ($4008/$400A/$400B): 11-bit period timer, 7-bit linear counter and 8-bit length counter.
- Emits oStep, a single-cycle pulse wired to triangle_generator iEnable, so the 4-bit up/down sequencer advances only when the timer expires and both counters are non-zero.
- Also drives the length-active status bit for the $4015 read path.

---
 rtl/apu_pkg.sv | 31 +++
 rtl/apu_length_counter.sv | 36 +++
 rtl/triangle_timer_ctrl.sv | 125 ++++++++++++
 tb/tb_triangle_timer_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/apu_pkg.sv
// Shared APU definitions: register addresses, counter widths and the length lookup table.
// Imported by the triangle channel and by the reusable length counter.
package apu_pkg;

    localparam int PERIOD_W = 11;
    localparam int LIN_W    = 7;
    localparam int LEN_W    = 8;

    localparam logic [1:0] TRI_LINEAR = 2'd0;
    localparam logic [1:0] TRI_LO     = 2'd2;
    localparam logic [1:0] TRI_HI     = 2'd3;

    // Index is the 5-bit field d[7:3] of the channel's high/length register write.
    localparam logic [LEN_W-1:0] LEN_TABLE [0:31] = '{
        8'd10,  8'd254, 8'd20, 8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
        8'd160, 8'd8,   8'd60, 8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
        8'd12,  8'd16,  8'd24, 8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
        8'd192, 8'd24,  8'd72, 8'd26, 8'd16, 8'd28, 8'd32, 8'd30
    };

    function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
        return LEN_TABLE[idx];
    endfunction

    typedef struct packed {
        logic                control;
        logic [LIN_W-1:0]    reload_val;
        logic [PERIOD_W-1:0] period;
    } tri_regs_t;

endpackage

// File: rtl/apu_length_counter.sv
// APU length counter: table load, halt, half-frame decrement and channel-enable clear.
// Shared by the pulse, triangle and noise channels.
module apu_length_counter
    import apu_pkg::*;
(
    input  logic             iClk,
    input  logic             iReset,
    input  logic             iEnable,
    input  logic             iHalt,
    input  logic             iHalfFrame,
    input  logic             iLoad,
    input  logic [4:0]       iLoadIdx,
    output logic [LEN_W-1:0] oLength,
    output logic             oActive
);

    logic [LEN_W-1:0] r_length;

    // A disabled channel clears the counter and ignores loads; a load beats a same-cycle decrement.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_length <= '0;
        end else if (!iEnable) begin
            r_length <= '0;
        end else if (iLoad) begin
            r_length <= len_lookup(iLoadIdx);
        end else if (iHalfFrame && !iHalt && (r_length != '0)) begin
            r_length <= r_length - 1'b1;
        end
    end

    assign oLength = r_length;
    assign oActive = (r_length != '0);

endmodule

// File: rtl/triangle_timer_ctrl.sv
// Triangle channel control: register file, period timer, linear counter and length counter.
// oStep is a one-cycle pulse that advances the triangle sequencer.
module triangle_timer_ctrl
    import apu_pkg::*;
#(
    parameter int MIN_PERIOD = 2
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iCpuTick,
    input  logic       iQuarterFrame,
    input  logic       iHalfFrame,
    input  logic       iWrEn,
    input  logic [1:0] iAddr,
    input  logic [7:0] iWrData,
    input  logic       iChanEnable,
    output logic       oStep,
    output logic       oLengthActive
);

    tri_regs_t            r_regs;
    logic [PERIOD_W-1:0]  r_timer;
    logic [LIN_W-1:0]     r_linear;
    logic                 r_reload_flag;
    logic                 r_step;

    logic                 w_wr_linear;
    logic                 w_wr_lo;
    logic                 w_wr_hi;
    logic [LEN_W-1:0]     w_length;
    logic                 w_length_active;
    logic                 w_period_ok;
    logic                 w_step_gate;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_wr_linear = 1'b0;
        w_wr_lo     = 1'b0;
        w_wr_hi     = 1'b0;
        if (iWrEn) begin
            case (iAddr)
                TRI_LINEAR: w_wr_linear = 1'b1;
                TRI_LO:     w_wr_lo     = 1'b1;
                TRI_HI:     w_wr_hi     = 1'b1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_regs <= '0;
        end else begin
            if (w_wr_linear) begin
                r_regs.control    <= iWrData[7];
                r_regs.reload_val <= iWrData[6:0];
            end
            if (w_wr_lo) begin
                r_regs.period[7:0] <= iWrData;
            end
            if (w_wr_hi) begin
                r_regs.period[10:8] <= iWrData[2:0];
            end
        end
    end

    // Periods below MIN_PERIOD would be ultrasonic; MIN_PERIOD of 0 never suppresses.
    assign w_period_ok = (int'(r_regs.period) >= MIN_PERIOD);
    assign w_step_gate = (r_linear != '0) && (w_length != '0) && w_period_ok;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_timer <= '0;
            r_step  <= 1'b0;
        end else begin
            r_step <= 1'b0;
            if (iCpuTick) begin
                if (r_timer == '0) begin
                    r_timer <= r_regs.period;
                    r_step  <= w_step_gate;
                end else begin
                    r_timer <= r_timer - 1'b1;
                end
            end
        end
    end

    // A high-register write issued alongside a quarter frame still leaves the reload flag set.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_linear      <= '0;
            r_reload_flag <= 1'b0;
        end else begin
            if (iQuarterFrame) begin
                if (r_reload_flag) begin
                    r_linear <= r_regs.reload_val;
                end else if (r_linear != '0) begin
                    r_linear <= r_linear - 1'b1;
                end
                if (!r_regs.control) begin
                    r_reload_flag <= 1'b0;
                end
            end
            if (w_wr_hi) begin
                r_reload_flag <= 1'b1;
            end
        end
    end

    apu_length_counter u_len (
        .iClk       (iClk),
        .iReset     (iReset),
        .iEnable    (iChanEnable),
        .iHalt      (r_regs.control),
        .iHalfFrame (iHalfFrame),
        .iLoad      (w_wr_hi),
        .iLoadIdx   (iWrData[7:3]),
        .oLength    (w_length),
        .oActive    (w_length_active)
    );

    assign oStep         = r_step;
    assign oLengthActive = w_length_active;

endmodule

// File: tb/tb_triangle_timer_ctrl.sv
// Directed bench for triangle_timer_ctrl with hand-computed expectations.
module tb_triangle_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cpu_tick = 1'b0;
    logic       quarter = 1'b0;
    logic       half = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       chan_en = 1'b1;
    logic       step_out;
    logic       len_active;

    int n_total = 0;
    int n_bad   = 0;

    triangle_timer_ctrl #(.MIN_PERIOD(2)) dut (
        .iClk          (clk),
        .iReset        (rst),
        .iCpuTick      (cpu_tick),
        .iQuarterFrame (quarter),
        .iHalfFrame    (half),
        .iWrEn         (wr_en),
        .iAddr         (addr),
        .iWrData       (wr_data),
        .iChanEnable   (chan_en),
        .oStep         (step_out),
        .oLengthActive (len_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic qframe();
        quarter = 1'b1;
        cycle();
        quarter = 1'b0;
    endtask

    task automatic hframe();
        half = 1'b1;
        cycle();
        half = 1'b0;
    endtask

    initial begin
        int found;

        // Reset
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_step", step_out, 0);
        check("rst_active", len_active, 0);
        check("rst_length", dut.u_len.r_length, 0);
        check("rst_linear", dut.r_linear, 0);

        // Basic programming: control=1 reload=1, period=4, length index 1 -> 254
        wr(2'd0, 8'h81);
        wr(2'd2, 8'h04);
        wr(2'd3, 8'h08);
        check("t1_length", dut.u_len.r_length, 254);
        check("t1_active", len_active, 1);
        qframe();
        check("t1_linear", dut.r_linear, 1);

        // Timer starts at 0: pulse after first tick edge, then every 5 clocks
        cpu_tick = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cycle();
            check($sformatf("t1_step%0d", i), step_out, (i % 5 == 0) ? 1 : 0);
        end
        cpu_tick = 1'b0;

        // Linear counter: reload then count down with control=0
        wr(2'd0, 8'h02);
        wr(2'd3, 8'h08);
        qframe();
        check("t2_lin_a", dut.r_linear, 2);
        qframe();
        check("t2_lin_b", dut.r_linear, 1);
        qframe();
        check("t2_lin_c", dut.r_linear, 0);
        qframe();
        check("t2_lin_d", dut.r_linear, 0);
        cpu_tick = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (step_out) found++;
        end
        cpu_tick = 1'b0;
        check("t2_no_steps", found, 0);

        // Length countdown from 2 with halt released
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h18);
        check("t3_len_load", dut.u_len.r_length, 2);
        hframe();
        check("t3_len_1", dut.u_len.r_length, 1);
        check("t3_act_1", len_active, 1);
        hframe();
        check("t3_len_0", dut.u_len.r_length, 0);
        check("t3_act_0", len_active, 0);
        hframe();
        check("t3_len_sat", dut.u_len.r_length, 0);

        // Load beats same-cycle half-frame decrement
        half = 1'b1;
        wr(2'd3, 8'h08);
        half = 1'b0;
        check("t4_load_wins", dut.u_len.r_length, 254);
        // Quarter frame uses the pre-write reload value (0, not 127)
        quarter = 1'b1;
        wr(2'd0, 8'h7F);
        quarter = 1'b0;
        check("t4_old_reload", dut.r_linear, 0);
        wr(2'd3, 8'h08);
        qframe();
        check("t4_new_reload", dut.r_linear, 127);
        // High write alongside quarter frame: decrement now, flag stays set
        wr(2'd0, 8'h05);
        quarter = 1'b1;
        wr(2'd3, 8'h08);
        quarter = 1'b0;
        check("t4_dec_same", dut.r_linear, 126);
        qframe();
        check("t4_flag_kept", dut.r_linear, 5);

        // Channel disable clears length and blocks steps and loads
        chan_en = 1'b0;
        cycle();
        check("t5_len_clr", dut.u_len.r_length, 0);
        check("t5_act_clr", len_active, 0);
        cpu_tick = 1'b1;
        found = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (step_out) found++;
        end
        cpu_tick = 1'b0;
        check("t5_no_steps", found, 0);
        wr(2'd3, 8'hF9);
        check("t5_no_load", dut.u_len.r_length, 0);
        check("t5_period_hi", dut.r_regs.period, 11'h104);
        chan_en = 1'b1;

        // Period 1 is below MIN_PERIOD: no steps
        wr(2'd2, 8'h01);
        wr(2'd3, 8'h08);
        check("t6_period", dut.r_regs.period, 1);
        qframe();
        check("t6_linear", dut.r_linear, 5);
        cpu_tick = 1'b1;
        found = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (step_out) found++;
        end
        cpu_tick = 1'b0;
        check("t6_suppressed", found, 0);

        // Reset exactly on the edge that would raise the next pulse
        wr(2'd2, 8'h04);
        cpu_tick = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (step_out) begin
                found = 1;
                break;
            end
        end
        check("t7_pulse_seen", found, 1);
        found = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (step_out) found++;
        end
        check("t7_gap", found, 0);
        rst = 1'b1;
        cycle();
        check("t7_step", step_out, 0);
        check("t7_active", len_active, 0);
        check("t7_linear", dut.r_linear, 0);
        check("t7_timer", dut.r_timer, 0);
        check("t7_period", dut.r_regs.period, 0);
        rst = 1'b0;
        cpu_tick = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
